// File: rtl/turbo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turbo_pkg
// Description : Shared constants for the HPGP turbo RX interleaver. Holds
//               the PB length/offset tables, the pb_sel encodings, the
//               write-controller state encoding and the PB size decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package turbo_pkg;

    // pb_sel encodings
    localparam logic [1:0] c_PB_SEL_16      = 2'd0;
    localparam logic [1:0] c_PB_SEL_136     = 2'd1;
    localparam logic [1:0] c_PB_SEL_520     = 2'd2;
    localparam logic [1:0] c_PB_SEL_ILLEGAL = 2'd3;

    // PB lengths in 2-bit symbols (octets * 4)
    localparam logic [11:0] c_PB_LEN_16  = 12'h040;
    localparam logic [11:0] c_PB_LEN_136 = 12'h220;
    localparam logic [11:0] c_PB_LEN_520 = 12'h820;

    // PB base offsets in the interleaver RAM
    localparam logic [11:0] c_PB_OFF_16  = 12'h000;
    localparam logic [11:0] c_PB_OFF_136 = 12'h010;
    localparam logic [11:0] c_PB_OFF_520 = 12'h098;

    // Write-controller state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_START = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    typedef struct packed {
        logic        legal;
        logic [11:0] len;
        logic [11:0] offset;
    } pb_geom_t;

    // Map pb_sel to PB geometry; the illegal code returns legal = 0.
    function automatic pb_geom_t pb_decode(input logic [1:0] sel);
        pb_geom_t g;
        g = '{legal: 1'b0, len: 12'h000, offset: 12'h000};
        case (sel)
            c_PB_SEL_16:  g = '{legal: 1'b1, len: c_PB_LEN_16,  offset: c_PB_OFF_16};
            c_PB_SEL_136: g = '{legal: 1'b1, len: c_PB_LEN_136, offset: c_PB_OFF_136};
            c_PB_SEL_520: g = '{legal: 1'b1, len: c_PB_LEN_520, offset: c_PB_OFF_520};
            default:      g = '{legal: 1'b0, len: 12'h000, offset: 12'h000};
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turbo_rx_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turbo_rx_wr_ctrl
// Description : Write-side controller of the turbo RX interleaver memory.
//               Accepts the serial soft-symbol stream of one PB, writes it
//               at the size-dependent RAM offset, then pulses start to the
//               read stage and blocks input until the read pass is over.
// Ports       : clk, rst         - clock, async active-high reset
//               sof, pb_sel      - start-of-PB pulse and PB size select
//               din/din_vld/din_rdy - symbol input handshake
//               wen/waddr/wdata  - RAM write port (registered)
//               pb_len/pb_offset - PB geometry for the read stage
//               start            - one-cycle read-stage kick-off
//               busy, err        - status; err pulses on illegal/late sof
// Revision    : 1.0 - initial release
// ============================================================================
module turbo_rx_wr_ctrl
    import turbo_pkg::*;
#(
    parameter int D_WIDTH = 2,
    parameter int A_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sof,
    input  logic [1:0]         pb_sel,
    input  logic [D_WIDTH-1:0] din,
    input  logic               din_vld,
    output logic               din_rdy,
    output logic               wen,
    output logic [A_WIDTH-1:0] waddr,
    output logic [D_WIDTH-1:0] wdata,
    output logic [A_WIDTH-1:0] pb_len,
    output logic [A_WIDTH-1:0] pb_offset,
    output logic               start,
    output logic               busy,
    output logic               err
);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [A_WIDTH-1:0] r_wcnt;
    logic [A_WIDTH-1:0] r_dcnt;
    logic [A_WIDTH-1:0] r_pb_len;
    logic [A_WIDTH-1:0] r_pb_offset;
    logic [A_WIDTH-1:0] r_waddr;
    logic [D_WIDTH-1:0] r_wdata;
    logic               r_din_rdy;
    logic               r_wen;
    logic               r_start;
    logic               r_err;

    pb_geom_t           w_geom;
    logic               w_accept;
    logic               w_load;
    logic               w_err;
    logic               w_last;

    assign w_geom = pb_decode(pb_sel);
    assign w_last = (r_wcnt == (r_pb_len - A_WIDTH'(1)));

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (sof) begin
                    if (w_geom.legal) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_ST_FILL;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            c_ST_FILL: begin
                // sof restarts the PB; a symbol on the same cycle is dropped
                if (sof) begin
                    w_err = 1'b1;
                    if (w_geom.legal) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (din_vld && r_din_rdy) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_state_nxt = c_ST_FILL == c_ST_FILL ? c_ST_START : c_ST_FILL;
                    end
                end
            end
            c_ST_START: begin
                w_err       = sof;
                w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                w_err = sof;
                if (r_dcnt == A_WIDTH'(1)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_wcnt      <= '0;
            r_dcnt      <= '0;
            r_pb_len    <= '0;
            r_pb_offset <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_din_rdy   <= 1'b0;
            r_wen       <= 1'b0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Registered from next state so it drops on entry to START
            r_din_rdy <= (w_state_nxt == c_ST_FILL);
            r_wen     <= w_accept;
            r_err     <= w_err;
            // One cycle behind START so it follows the last write
            r_start   <= (r_state == c_ST_START);

            if (w_load) begin
                r_pb_len    <= A_WIDTH'(w_geom.len);
                r_pb_offset <= A_WIDTH'(w_geom.offset);
                r_wcnt      <= '0;
            end else if (w_accept) begin
                r_wcnt <= r_wcnt + A_WIDTH'(1);
            end

            if (w_accept) begin
                r_waddr <= r_pb_offset + r_wcnt;
                r_wdata <= din;
            end

            // Quarter-length read pass plus the read stage output register
            if (r_state == c_ST_START) begin
                r_dcnt <= {2'b00, r_pb_len[A_WIDTH-1:2]} + A_WIDTH'(2);
            end else if (r_state == c_ST_DRAIN) begin
                r_dcnt <= r_dcnt - A_WIDTH'(1);
            end
        end
    end

    assign din_rdy   = r_din_rdy;
    assign wen       = r_wen;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign pb_len    = r_pb_len;
    assign pb_offset = r_pb_offset;
    assign start     = r_start;
    assign err       = r_err;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
